// File: rtl/seven_segments_monitor_if.sv
// Snooped 7-segment display bus plus the decoded-frame readback
// produced by the monitor.
interface seven_segments_monitor_if #(
  parameter int NUM_DIGITS = 8
);
  logic [6:0]              seg_n;
  logic [NUM_DIGITS-1:0]   an_n;
  logic [4*NUM_DIGITS-1:0] value;
  logic [NUM_DIGITS-1:0]   blank;
  logic [NUM_DIGITS-1:0]   err;
  logic                    frame_valid;
  logic                    frame_err;

  modport master (
    output seg_n, an_n,
    input  value, blank, err, frame_valid, frame_err
  );

  modport slave (
    input  seg_n, an_n,
    output value, blank, err, frame_valid, frame_err
  );
endinterface

// File: rtl/seven_segments_monitor.sv
// Debounces the multiplexed active-low segment/anode bus, decodes each
// digit back to a hex nibble and publishes a complete frame.
module seven_segments_monitor #(
  parameter int NUM_DIGITS    = 8,
  parameter int STABLE_CYCLES = 4
) (
  input logic                      clock,
  input logic                      reset,
  seven_segments_monitor_if.slave  bus
);
  localparam int CW = $clog2(STABLE_CYCLES + 1);

  typedef struct packed {
    logic       err;
    logic       blank;
    logic [3:0] nib;
  } dec_t;

  function automatic dec_t decode(input logic [6:0] seg);
    dec_t d;
    d = '{err: 1'b0, blank: 1'b0, nib: 4'h0};
    case (seg)
      7'b1000000: d.nib = 4'h0;
      7'b1111001: d.nib = 4'h1;
      7'b0100100: d.nib = 4'h2;
      7'b0110000: d.nib = 4'h3;
      7'b0011001: d.nib = 4'h4;
      7'b0010010: d.nib = 4'h5;
      7'b0000011,
      7'b0000010: d.nib = 4'h6;  // 0000011 is also hex B; reported as 6
      7'b1111000: d.nib = 4'h7;
      7'b0000000: d.nib = 4'h8;
      7'b0011000,
      7'b0010000: d.nib = 4'h9;
      7'b0001000: d.nib = 4'hA;
      7'b0100111: d.nib = 4'hC;
      7'b0100001: d.nib = 4'hD;
      7'b0000110: d.nib = 4'hE;
      7'b0001110: d.nib = 4'hF;
      7'b1111111: d.blank = 1'b1;
      default:    d.err = 1'b1;
    endcase
    return d;
  endfunction

  logic [6:0]                 s_seg, p_seg;
  logic [NUM_DIGITS-1:0]      s_an, p_an;
  logic [CW-1:0]              cnt, run_len;
  logic                       cap_flag, frame_pend;
  logic [NUM_DIGITS-1:0]      seen, seen_base, cap_mask, an_act;
  logic [NUM_DIGITS-1:0][3:0] stg_nib, val_q;
  logic [NUM_DIGITS-1:0]      stg_blank, stg_err, blank_q, err_q;
  logic                       fv_q, ferr_q;
  logic                       s_valid, same, capture;
  dec_t                       dec;

  always_comb begin
    an_act    = ~s_an;
    s_valid   = (an_act != '0) && ((an_act & (an_act - 1'b1)) == '0);
    same      = (s_seg == p_seg) && (s_an == p_an);
    run_len   = '0;
    if (s_valid)
      run_len = !same ? CW'(1) :
                (cnt == CW'(STABLE_CYCLES)) ? cnt : cnt + 1'b1;
    // one capture per dwell: the flag only drops when the sample changes
    capture   = (run_len == CW'(STABLE_CYCLES)) && !(cap_flag && same);
    cap_mask  = capture ? an_act : '0;
    seen_base = frame_pend ? '0 : seen;
    dec       = decode(s_seg);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      // idle bus (no anode driven) so the first sample is never valid
      s_seg      <= '1;
      s_an       <= '1;
      p_seg      <= '1;
      p_an       <= '1;
      cnt        <= '0;
      cap_flag   <= 1'b0;
      seen       <= '0;
      frame_pend <= 1'b0;
      stg_nib    <= '0;
      stg_blank  <= '0;
      stg_err    <= '0;
      val_q      <= '0;
      blank_q    <= '0;
      err_q      <= '0;
      fv_q       <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      s_seg <= bus.seg_n;
      s_an  <= bus.an_n;
      p_seg <= s_seg;
      p_an  <= s_an;
      cnt   <= run_len;
      if (capture)   cap_flag <= 1'b1;
      else if (!same) cap_flag <= 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (cap_mask[i]) begin
          stg_nib[i]   <= dec.nib;
          stg_blank[i] <= dec.blank;
          stg_err[i]   <= dec.err;
        end
      end
      seen       <= seen_base | cap_mask;
      frame_pend <= capture && ((seen_base | cap_mask) == '1);
      fv_q       <= frame_pend;
      if (frame_pend) begin
        val_q   <= stg_nib;
        blank_q <= stg_blank;
        err_q   <= stg_err;
        ferr_q  <= |stg_err;
      end
    end
  end

  assign bus.value       = val_q;
  assign bus.blank       = blank_q;
  assign bus.err         = err_q;
  assign bus.frame_valid = fv_q;
  assign bus.frame_err   = ferr_q;
endmodule

// File: tb/tb_seven_segments_monitor.sv
// Scoreboard bench: expected frames queued as each scan is driven,
// popped and compared whenever the monitor pulses frame_valid.
module tb_seven_segments_monitor;
  logic clock = 1'b0;
  logic reset;
  int   checks = 0, failures = 0;
  int   fv_cnt = 0, last_fv_cyc = 0, cyc = 0;

  typedef struct {
    logic [31:0] v;
    logic [7:0]  b;
    logic [7:0]  e;
    logic        fe;
  } frame_t;
  frame_t sb[$];
  frame_t got_f;

  seven_segments_monitor_if #(.NUM_DIGITS(8)) bus ();

  seven_segments_monitor #(.NUM_DIGITS(8), .STABLE_CYCLES(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] seg_of(input logic [3:0] n);
    case (n)
      4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;  4'hC: return 7'b0100111;
      4'hD: return 7'b0100001;  4'hE: return 7'b0000110;
      4'hF: return 7'b0001110;  default: return 7'b1111111;
    endcase
  endfunction

  task automatic hold_raw(input logic [7:0] an, input logic [6:0] seg, input int n);
    bus.an_n  = an;
    bus.seg_n = seg;
    repeat (n) @(negedge clock);
  endtask

  task automatic hold(input int d, input logic [6:0] seg, input int n);
    logic [7:0] one;
    one = 8'd1;
    hold_raw(~(one << d), seg, n);
  endtask

  task automatic idle(input int n);
    hold_raw(8'hFF, 7'b1111111, n);
  endtask

  task automatic push(input logic [31:0] v, input logic [7:0] b, input logic [7:0] e, input logic fe);
    frame_t f;
    f.v = v; f.b = b; f.e = e; f.fe = fe;
    sb.push_back(f);
  endtask

  always @(negedge clock) begin
    if (!reset && bus.frame_valid) begin
      fv_cnt++;
      last_fv_cyc = cyc;
      if (sb.size() == 0) chk("unexpected_frame", 1, 0);
      else begin
        got_f = sb.pop_front();
        chk("value", bus.value, got_f.v);
        chk("blank", bus.blank, got_f.b);
        chk("err", bus.err, got_f.e);
        chk("frame_err", bus.frame_err, got_f.fe);
      end
    end
  end

  initial begin
    int base, t0;
    logic [31:0] v;
    reset = 1'b1;
    bus.seg_n = '1;
    bus.an_n  = '1;
    repeat (3) @(negedge clock);
    chk("rst_value", bus.value, 0);
    chk("rst_blank", bus.blank, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_fv", bus.frame_valid, 0);
    chk("rst_ferr", bus.frame_err, 0);
    reset = 1'b0;
    idle(3);

    // full scan 1..8, pin-to-frame_valid latency on the last digit
    push(32'h87654321, 8'h00, 8'h00, 1'b0);
    base = fv_cnt;
    for (int d = 0; d < 7; d++) hold(d, seg_of(4'(d + 1)), 6);
    t0 = cyc;
    hold(7, seg_of(4'h8), 6);
    idle(4);
    chk("t1_frames", fv_cnt - base, 1);
    chk("t1_latency", last_fv_cyc - t0, 6);

    // short dwell on digit 3 is not captured
    v = 32'h7FEDCA90;
    base = fv_cnt;
    for (int d = 0; d < 8; d++) hold(d, seg_of(v[4*d +: 4]), (d == 3) ? 3 : 6);
    idle(4);
    chk("t2_no_frame", fv_cnt - base, 0);
    push(v, 8'h00, 8'h00, 1'b0);
    hold(3, seg_of(4'hC), 6);
    idle(4);
    chk("t2_frames", fv_cnt - base, 1);

    // blank digit 0, undecodable digit 5
    push(32'h00000000, 8'h01, 8'h20, 1'b1);
    base = fv_cnt;
    for (int d = 0; d < 8; d++)
      hold(d, (d == 0) ? 7'b1111111 : (d == 5) ? 7'b0101010 : seg_of(4'h0), 6);
    idle(4);
    chk("t3_frames", fv_cnt - base, 1);

    // two anodes / no anodes: never captured, earlier staging survives
    v = 32'h5E0D7921;
    base = fv_cnt;
    for (int d = 0; d < 7; d++) hold(d, seg_of(v[4*d +: 4]), 6);
    hold_raw(8'hFC, 7'b0000000, 20);
    hold_raw(8'hFF, 7'b0000000, 20);
    chk("t4_no_frame", fv_cnt - base, 0);
    push(v, 8'h00, 8'h00, 1'b0);
    hold(7, seg_of(4'h5), 6);
    idle(4);
    chk("t4_frames", fv_cnt - base, 1);

    // digit 2 recaptured (4 then alternate 9), alternate 6 on digit 7
    push(32'h6A0DE953, 8'h00, 8'h00, 1'b0);
    base = fv_cnt;
    hold(0, seg_of(4'h3), 6);
    hold(1, seg_of(4'h5), 6);
    hold(2, seg_of(4'h4), 6);
    hold(3, seg_of(4'hE), 6);
    hold(4, seg_of(4'hD), 6);
    hold(2, 7'b0011000, 6);
    hold(5, seg_of(4'h0), 6);
    hold(6, seg_of(4'hA), 6);
    hold(7, 7'b0000011, 6);
    idle(4);
    chk("t5_frames", fv_cnt - base, 1);

    // reset discards a partial frame
    for (int d = 0; d < 5; d++) hold(d, seg_of(4'h1), 6);
    reset = 1'b1;
    idle(3);
    chk("t6_rst_value", bus.value, 0);
    chk("t6_rst_ferr", bus.frame_err, 0);
    reset = 1'b0;
    idle(2);
    v = 32'h1234CDEF;
    base = fv_cnt;
    for (int d = 0; d < 7; d++) hold(d, seg_of(v[4*d +: 4]), 6);
    chk("t6_no_early_frame", fv_cnt - base, 0);
    push(v, 8'h00, 8'h00, 1'b0);
    hold(7, seg_of(4'h1), 6);
    idle(4);
    chk("t6_frames", fv_cnt - base, 1);

    // long dwell captures once
    push(32'h88888887, 8'h00, 8'h00, 1'b0);
    base = fv_cnt;
    hold(0, seg_of(4'h7), 40);
    chk("t6_long_no_frame", fv_cnt - base, 0);
    for (int d = 1; d < 8; d++) hold(d, seg_of(4'h8), 6);
    idle(6);
    chk("t6_long_frames", fv_cnt - base, 1);

    chk("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
